// File: rtl/freq_counter_mc.sv
`default_nettype none
// ============================================================================
// Module      : freq_counter_mc
// Description : Multi-channel frequency counter. Counts rising edges on N_CH
//               asynchronous inputs over a shared gate window (1 s, 100 ms or
//               10 ms). Each count is scaled to Hz and saturates with an
//               overflow flag. A registered mux selects one channel for display.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_counter_mc #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_CH-1:0]         IN,
  input  logic [1:0]              MODE,
  input  logic [SEL_W-1:0]        SEL,
  output logic [N_CH*CNT_W-1:0]   freq,
  output logic [N_CH-1:0]         overflow,
  output logic                    valid,
  output logic [CNT_W-1:0]        freq_sel
);

  // Gate counter width covers the longest window (GATE_CYCLES-1).
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] C_G0_MAX = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0] C_G1_MAX = GW'(GATE_CYCLES / 10 - 1);
  localparam logic [GW-1:0] C_G2_MAX = GW'(GATE_CYCLES / 100 - 1);
  // Scaling headroom: x100 needs 7 extra bits.
  localparam int PW = CNT_W + 7;

  generate
    if ((GATE_CYCLES % 100) != 0 || GATE_CYCLES < 100) begin : g_bad_gate
      $error("GATE_CYCLES must be a non-zero multiple of 100");
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
      $error("N_CH must be in 1..16");
    end
  endgenerate

  logic [GW-1:0] gate_cnt;
  logic [GW-1:0] gate_max;
  logic [1:0]    mode_q;
  logic          mode_chg;
  logic          tick;

  // Gate length for the current MODE; the reserved code falls back to 1 s.
  always_comb begin
    case (MODE)
      2'd1:    gate_max = C_G1_MAX;
      2'd2:    gate_max = C_G2_MAX;
      default: gate_max = C_G0_MAX;
    endcase
  end

  assign mode_chg = (MODE != mode_q);
  assign tick     = (gate_cnt == gate_max);

  // Gate counter; a MODE change restarts the window. mode_q tracks MODE even
  // in reset so a MODE held through reset is not seen as a change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gate_cnt <= '0;
      mode_q   <= MODE;
      valid    <= 1'b0;
    end else begin
      mode_q <= MODE;
      valid  <= tick & ~mode_chg;
      if (mode_chg || tick) begin
        gate_cnt <= '0;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
      end
    end
  end

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic             sync1;
      logic             sync2;
      logic             prev;
      logic             edge_det;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             ovf;
      logic             ovf_nxt;
      logic [PW-1:0]    ext;
      logic [PW-1:0]    prod;
      logic             prod_ovf;
      logic [CNT_W-1:0] res;
      logic             res_ovf;
      logic [CNT_W-1:0] freq_r;
      logic             ovf_r;

      assign edge_det = sync2 & ~prev;

      // Count including this cycle's edge, so a tick-cycle edge lands in the
      // closing window rather than being lost on the clear.
      always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (edge_det) begin
          if (&cnt) begin
            ovf_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      // Shift-add scaling to Hz with saturation on the extended product.
      always_comb begin
        ext = {7'b0, cnt_nxt};
        case (MODE)
          2'd1:    prod = (ext << 3) + (ext << 1);
          2'd2:    prod = (ext << 6) + (ext << 5) + (ext << 2);
          default: prod = ext;
        endcase
        prod_ovf = |prod[PW-1:CNT_W];
        res      = prod_ovf ? {CNT_W{1'b1}} : prod[CNT_W-1:0];
        res_ovf  = ovf_nxt | prod_ovf;
      end

      // Synchroniser, edge counter and result register for this channel.
      always_ff @(posedge CLK) begin
        if (RST) begin
          sync1  <= 1'b0;
          sync2  <= 1'b0;
          prev   <= 1'b0;
          cnt    <= '0;
          ovf    <= 1'b0;
          freq_r <= '0;
          ovf_r  <= 1'b0;
        end else begin
          sync1 <= IN[k];
          sync2 <= sync1;
          prev  <= sync2;
          if (mode_chg) begin
            cnt <= '0;
            ovf <= 1'b0;
          end else if (tick) begin
            cnt    <= '0;
            ovf    <= 1'b0;
            freq_r <= res;
            ovf_r  <= res_ovf;
          end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
          end
        end
      end

      assign freq[k*CNT_W +: CNT_W] = freq_r;
      assign overflow[k]            = ovf_r;
    end
  endgenerate

  logic [CNT_W-1:0] sel_val;

  // Display mux; a SEL beyond the last channel matches nothing and gives 0.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (SEL == SEL_W'(k)) begin
        sel_val = freq[k*CNT_W +: CNT_W];
      end
    end
  end

  // Registered display value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      freq_sel <= '0;
    end else begin
      freq_sel <= sel_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_counter_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_counter_mc
// Description : Directed self-checking bench for freq_counter_mc. Two
//               instances share all stimulus: u_a with CNT_W=32 and u_b with
//               CNT_W=8 for saturation cases. GATE_CYCLES=1000, N_CH=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_counter_mc;

  logic        CLK;
  logic        RST;
  logic        in0;
  logic [1:0]  MODE;
  logic        SEL;
  logic [63:0] freq_a;
  logic [1:0]  ovf_a;
  logic        valid_a;
  logic [31:0] fsel_a;
  logic [15:0] freq_b;
  logic [1:0]  ovf_b;
  logic        valid_b;
  logic [7:0]  fsel_b;

  int vectors = 0;
  int errors  = 0;
  int half    = 0;   // generator half-period in cycles; 0 = main drives in0
  int ph      = 0;
  int n;

  freq_counter_mc #(.CLK_HZ(1000), .GATE_CYCLES(1000), .N_CH(2), .CNT_W(32)) u_a (
    .CLK(CLK), .RST(RST), .IN({1'b0, in0}), .MODE(MODE), .SEL(SEL),
    .freq(freq_a), .overflow(ovf_a), .valid(valid_a), .freq_sel(fsel_a)
  );

  freq_counter_mc #(.CLK_HZ(1000), .GATE_CYCLES(1000), .N_CH(2), .CNT_W(8)) u_b (
    .CLK(CLK), .RST(RST), .IN({1'b0, in0}), .MODE(MODE), .SEL(SEL),
    .freq(freq_b), .overflow(ovf_b), .valid(valid_b), .freq_sel(fsel_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Square-wave generator on in0, updated 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (half > 0) begin
        ph++;
        if (ph >= half) begin
          ph  = 0;
          in0 = ~in0;
        end
      end else begin
        ph = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic step_n(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  // Advance until valid_a is seen; returns the number of edges taken (capped).
  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!valid_a && cnt < budget);
  endtask

  initial begin
    RST  = 1'b1;
    in0  = 1'b1;
    MODE = 2'd0;
    SEL  = 1'b0;

    // Reset values, with IN held high through reset.
    step_n(3);
    check_val("rst_freq", freq_a, 64'd0);
    check_val("rst_ovf", {62'd0, ovf_a}, 64'd0);
    check_val("rst_valid", {63'd0, valid_a}, 64'd0);
    check_val("rst_fsel", {32'd0, fsel_a}, 64'd0);

    // First window: exactly one edge from the held-high input; valid at G.
    RST = 1'b0;
    step_n(999);                       // edges k=0..998
    check_val("win1_no_early_valid", {63'd0, valid_a}, 64'd0);
    step();                            // k=999 = tick
    check_val("win1_valid", {63'd0, valid_a}, 64'd1);
    check_val("win1_held_high_ch0", {32'd0, freq_a[31:0]}, 64'd1);
    check_val("win1_ch1", {32'd0, freq_a[63:32]}, 64'd0);

    // Tick-cycle boundary: edges counted at k=999 and k=1001.
    RST = 1'b1;
    in0 = 1'b0;
    step_n(2);
    RST = 1'b0;
    step_n(997);                       // after k=996
    in0 = 1'b1; step();                // k=997
    in0 = 1'b0; step();                // k=998
    in0 = 1'b1; step();                // k=999
    check_val("tick_edge_valid", {63'd0, valid_a}, 64'd1);
    check_val("tick_edge_in_closing", {32'd0, freq_a[31:0]}, 64'd1);
    in0 = 1'b0; step();                // k=1000
    check_val("valid_one_cycle", {63'd0, valid_a}, 64'd0);
    check_val("freq_hold", {32'd0, freq_a[31:0]}, 64'd1);
    step_n(999);                       // k=1999
    check_val("next_win_edge", {32'd0, freq_a[31:0]}, 64'd1);

    // MODE 0, edge every 20 cycles: 50 Hz steady state, valid every 1000.
    half = 10;
    wait_valid(1010, n);
    check_val("m0_period_a", n, 1000);
    wait_valid(1010, n);
    check_val("m0_period_b", n, 1000);
    check_val("m0_ch0", {32'd0, freq_a[31:0]}, 64'd50);
    check_val("m0_ch1", {32'd0, freq_a[63:32]}, 64'd0);
    check_val("m0_ovf", {62'd0, ovf_a}, 64'd0);

    // Display mux follows SEL one cycle later.
    step();
    check_val("fsel_ch0", {32'd0, fsel_a}, 64'd50);
    SEL = 1'b1; step();
    check_val("fsel_ch1", {32'd0, fsel_a}, 64'd0);
    SEL = 1'b0; step();
    check_val("fsel_back", {32'd0, fsel_a}, 64'd50);

    // MODE 0->1 mid-window: aborted window gives no valid; new 100-cycle gate.
    step_n(300);
    MODE = 2'd1;
    wait_valid(120, n);
    check_val("m1_after_switch", n, 101);
    check_val("m1_first_ch0", {32'd0, freq_a[31:0]}, 64'd50);
    wait_valid(120, n);
    check_val("m1_period", n, 100);
    check_val("m1_ch0", {32'd0, freq_a[31:0]}, 64'd50);

    // MODE 2, edge every 2 clocks: 5 edges per 10-cycle window -> 500 Hz.
    MODE = 2'd2;
    half = 1;
    wait_valid(30, n);
    check_val("m2_after_switch", n, 11);
    wait_valid(30, n);
    check_val("m2_period", n, 10);
    check_val("m2_ch0", {32'd0, freq_a[31:0]}, 64'd500);

    // Reset in mid-window discards the partial window.
    MODE = 2'd0;
    wait_valid(1020, n);
    check_val("m0_after_switch", n, 1001);
    step_n(550);
    RST  = 1'b1;
    half = 0;
    in0  = 1'b0;
    step();
    check_val("midrst_freq", freq_a, 64'd0);
    check_val("midrst_valid", {63'd0, valid_a}, 64'd0);
    check_val("midrst_fsel", {32'd0, fsel_a}, 64'd0);
    check_val("midrst_freq_b", {48'd0, freq_b}, 64'd0);
    RST  = 1'b0;
    half = 10;
    wait_valid(1020, n);
    check_val("postrst_first_valid", n, 1000);
    check_val("postrst_ch0", {32'd0, freq_a[31:0]}, 64'd50);

    // CNT_W=8: 500 edges saturate the counter.
    half = 1;
    wait_valid(1010, n);
    check_val("sat_skip_period", n, 1000);
    wait_valid(1010, n);
    check_val("sat_period", n, 1000);
    check_val("sat_b_ch0", {56'd0, freq_b[7:0]}, 64'd255);
    check_val("sat_b_ovf", {62'd0, ovf_b}, 64'd1);
    check_val("sat_a_ch0", {32'd0, freq_a[31:0]}, 64'd500);
    check_val("sat_a_ovf", {62'd0, ovf_a}, 64'd0);

    // Next clean window with 100 edges clears the flag.
    half = 5;
    wait_valid(1010, n);
    check_val("rec_skip_period", n, 1000);
    wait_valid(1010, n);
    check_val("rec_b_ch0", {56'd0, freq_b[7:0]}, 64'd100);
    check_val("rec_b_ovf", {62'd0, ovf_b}, 64'd0);
    check_val("rec_a_ch0", {32'd0, freq_a[31:0]}, 64'd100);

    // MODE 1 on CNT_W=8: 50 edges x10 = 500 saturates via the product.
    MODE = 2'd1;
    half = 1;
    wait_valid(120, n);
    check_val("x10_after_switch", n, 101);
    wait_valid(120, n);
    check_val("x10_b_ch0", {56'd0, freq_b[7:0]}, 64'd255);
    check_val("x10_b_ovf", {62'd0, ovf_b}, 64'd1);
    check_val("x10_a_ch0", {32'd0, freq_a[31:0]}, 64'd500);

    // 25 edges x10 = 250 fits in 8 bits.
    half = 2;
    wait_valid(120, n);
    check_val("x10_fit_skip", n, 100);
    wait_valid(120, n);
    check_val("x10_fit_b_ch0", {56'd0, freq_b[7:0]}, 64'd250);
    check_val("x10_fit_b_ovf", {62'd0, ovf_b}, 64'd0);
    check_val("x10_fit_a_ch0", {32'd0, freq_a[31:0]}, 64'd250);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
